// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_PTR = 32'd1;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } fetch_req_t;

    // Saturating 32-bit increment used by the optional event counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Bundles the memory-side and core-side handshakes of the fetch sequencer.
interface fetch_controller_if;
    logic        redirect_valid;
    logic [31:0] redirect_ptr;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_ptr;

    // Fetch controller side.
    modport master (
        input  redirect_valid, redirect_ptr,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        output instr_valid, instr_out, instr_ptr,
        input  instr_ready
    );

    // Memory/core environment side.
    modport slave (
        output redirect_valid, redirect_ptr,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        input  instr_valid, instr_out, instr_ptr,
        output instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding prefetched instruction words.
// Flush wins over push and pop; the head word is readable combinationally.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             srst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointer and occupancy next-state; a flush simply empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
            else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
        end
    end

    // Pointer/occupancy registers.
    always_ff @(posedge clk) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port; contents need no reset because empty gates the head.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: issues word fetches under a credit limit,
// buffers the returned words and hands them to the core in order.
// Redirects flush the queue and drop every response still in flight.
// Optional FETCH_PERF_EN adds saturating stall/flush event counters.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] RESET_PTR = FETCH_RESET_PTR
) (
    input  logic               clk,
    input  logic               _reset,
`ifdef FETCH_PERF_EN
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt,
`endif
    fetch_controller_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_ptr_q, fetch_ptr_d;
    logic [31:0]   head_ptr_q, head_ptr_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    fetch_req_t    req;
    logic [CW:0]   credit_sum;
    logic          redirect_acc;
    logic          req_fire;
    logic          resp_take;
    logic          resp_drop;
    logic          q_push;
    logic          q_pop;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    logic [31:0]   q_head;

    fetch_queue #(.DEPTH(DEPTH), .WIDTH(32)) u_queue (
        .clk     (clk),
        .srst_i  (_reset),
        .flush_i (redirect_acc),
        .push_i  (q_push),
        .data_i  (bus.imem_resp_data),
        .pop_i   (q_pop),
        .head_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    // Requests in flight plus words already buffered never exceed DEPTH,
    // so every response has a free slot waiting for it.
    assign credit_sum   = {1'b0, outstanding_q} + {1'b0, q_count};
    assign req.valid    = (state_q == FETCH) && (credit_sum < DEPTH_W);
    assign req.addr     = fetch_ptr_q;
    assign redirect_acc = bus.redirect_valid && (state_q != IDLE);
    assign req_fire     = req.valid && bus.imem_req_ready;
    assign resp_take    = bus.imem_resp_valid && (outstanding_q != '0);
    assign resp_drop    = resp_take && ((drop_cnt_q != '0) || redirect_acc);
    assign q_push       = resp_take && !resp_drop;
    assign q_pop        = !q_empty && bus.instr_ready;

    assign bus.imem_req_valid = req.valid;
    assign bus.imem_req_addr  = req.addr;
    assign bus.instr_valid    = !q_empty;
    assign bus.instr_out      = q_empty ? 32'd0 : q_head;
    assign bus.instr_ptr      = head_ptr_q;

    // Next-state: credit accounting, pointer advance, redirect and drain.
    always_comb begin
        state_d       = state_q;
        fetch_ptr_d   = fetch_ptr_q;
        head_ptr_d    = head_ptr_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;

        if (req_fire && !resp_take)      outstanding_d = outstanding_q + CW'(1);
        else if (!req_fire && resp_take) outstanding_d = outstanding_q - CW'(1);

        if (req_fire) fetch_ptr_d = fetch_ptr_q + 32'd1;
        if (q_pop)    head_ptr_d  = head_ptr_q + 32'd1;
        if (resp_take && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);

        case (state_q)
            IDLE:    state_d = FETCH;
            DRAIN:   if (drop_cnt_d == '0) state_d = FETCH;
            default: state_d = state_q;
        endcase

        // Everything still in flight after this cycle belongs to the old
        // stream, including a request firing right now.
        if (redirect_acc) begin
            fetch_ptr_d = bus.redirect_ptr;
            head_ptr_d  = bus.redirect_ptr;
            drop_cnt_d  = outstanding_d;
            state_d     = (outstanding_d != '0) ? DRAIN : FETCH;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (_reset) begin
            state_q       <= IDLE;
            fetch_ptr_q   <= RESET_PTR;
            head_ptr_q    <= RESET_PTR;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_ptr_q   <= fetch_ptr_d;
            head_ptr_q    <= head_ptr_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // A push into a full queue would mean the credit limit was broken.
    assert property (@(posedge clk) disable iff (_reset) !(q_push && q_full && !q_pop));

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Event counters: core starved of instructions, and accepted redirects.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (bus.instr_ready && q_empty && (state_q != IDLE)) perf_stall_d = sat_inc32(perf_stall_q);
        if (redirect_acc) perf_flush_d = sat_inc32(perf_flush_q);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (_reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    // Counters absent in this build; core behaviour is unchanged.
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a fixed-latency memory model
// that returns addr*3 for every accepted request.
module tb_fetch_controller;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   lat    = 1;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] fire_log[$];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    fetch_controller_if bus ();

    fetch_controller #(.DEPTH(2), .RESET_PTR(32'd1)) dut (
        .clk            (clk),
        ._reset         (rst),
`ifdef FETCH_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .bus            (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: note the request handshake before the edge, then model memory.
    task automatic tick();
        logic        f;
        logic [31:0] a;
        f = bus.imem_req_valid && bus.imem_req_ready;
        a = bus.imem_req_addr;
        @(posedge clk);
        #1;
        cyc++;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'd0;
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            fire_log.delete();
        end else begin
            if (f) begin
                pend_addr.push_back(a);
                pend_due.push_back(cyc + lat - 1);
                fire_log.push_back(a);
            end
            if (pend_addr.size() > 0 && pend_due[0] == cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = pend_addr[0] * 32'd3;
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
        end
        $display("cyc=%0d req=%0b addr=%h resp=%0b ivalid=%0b iptr=%h iout=%h",
                 cyc, bus.imem_req_valid, bus.imem_req_addr, bus.imem_resp_valid,
                 bus.instr_valid, bus.instr_ptr, bus.instr_out);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Advance past the current head (if any) and wait for the next instruction.
    task automatic next_instr(input string tag, input logic [31:0] exp_ptr);
        int n;
        tick();
        n = 0;
        while (!bus.instr_valid && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, "_ptr"}, bus.instr_ptr, exp_ptr);
        chk({tag, "_out"}, bus.instr_out, exp_ptr * 32'd3);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_ptr    = 32'd0;
        bus.imem_req_ready  = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'd0;
        bus.instr_ready     = 1'b1;

        // 1: basic streaming, latency 1
        lat = 1;
        do_reset();
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr_out", bus.instr_out, 32'd0);
        chk("rst_instr_ptr", bus.instr_ptr, 32'd1);
        tick();
        chk("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t1_req_addr", bus.imem_req_addr, 32'd1);
        tick();
        tick();
        chk("t1_first_valid", 32'(bus.instr_valid), 32'd1);
        chk("t1_first_ptr", bus.instr_ptr, 32'd1);
        chk("t1_first_out", bus.instr_out, 32'd3);
        next_instr("t1_i2", 32'd2);
        next_instr("t1_i3", 32'd3);
        next_instr("t1_i4", 32'd4);

        // 2: back-pressure from the core; redirect in IDLE is ignored
        bus.instr_ready = 1'b0;
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_ptr   = 32'h500;
        tick();
        bus.redirect_valid = 1'b0;
        chk("t2_idle_redir_addr", bus.imem_req_addr, 32'd1);
        chk("t2_idle_redir_ptr", bus.instr_ptr, 32'd1);
        repeat (10) tick();
        chk("t2_fire_count", 32'(fire_log.size()), 32'd2);
        chk("t2_fire0", fire_log[0], 32'd1);
        chk("t2_fire1", fire_log[1], 32'd2);
        chk("t2_full_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("t2_head_ptr", bus.instr_ptr, 32'd1);
        chk("t2_head_out", bus.instr_out, 32'd3);
`ifdef FETCH_PERF_EN
        chk("t2_perf_flush", perf_flush_cnt, 32'd0);
`endif
        bus.instr_ready = 1'b1;
        next_instr("t2_i2", 32'd2);
        next_instr("t2_i3", 32'd3);
        chk("t2_resume_addr", fire_log[2], 32'd3);

        // 3: redirect with two requests in flight, latency 3
        lat = 3;
        do_reset();
        tick();
        tick();
        tick();
        chk("t3_outstanding", 32'(fire_log.size()), 32'd2);
        chk("t3_credit_stop", 32'(bus.imem_req_valid), 32'd0);
        bus.redirect_valid = 1'b1;
        bus.redirect_ptr   = 32'h40;
        tick();
        bus.redirect_valid = 1'b0;
        chk("t3_drain_req", 32'(bus.imem_req_valid), 32'd0);
        chk("t3_drain_instr", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("t3_drop1_instr", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("t3_refetch_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t3_refetch_addr", bus.imem_req_addr, 32'h40);
        next_instr("t3_i40", 32'h40);

        // 4: redirect coinciding with a response and a firing request
        lat = 1;
        do_reset();
        tick();
        tick();
        chk("t4_pre_req", 32'(bus.imem_req_valid), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_ptr   = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        chk("t4_fire_count", 32'(fire_log.size()), 32'd2);
        chk("t4_drain_req", 32'(bus.imem_req_valid), 32'd0);
        chk("t4_drain_instr", 32'(bus.instr_valid), 32'd0);
        tick();
        chk("t4_refetch_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t4_refetch_addr", bus.imem_req_addr, 32'h100);
        next_instr("t4_i100", 32'h100);

        // 5: second redirect while draining
        lat = 3;
        do_reset();
        tick();
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_ptr   = 32'h40;
        tick();
        bus.redirect_ptr   = 32'h80;
        tick();
        bus.redirect_valid = 1'b0;
        chk("t5_drain_req", 32'(bus.imem_req_valid), 32'd0);
        tick();
        chk("t5_fire_count", 32'(fire_log.size()), 32'd2);
        chk("t5_refetch_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t5_refetch_addr", bus.imem_req_addr, 32'h80);
        next_instr("t5_i80", 32'h80);
`ifdef FETCH_PERF_EN
        chk("t5_perf_flush", perf_flush_cnt, 32'd2);
`endif

        // 6: fetch pointer wrap, and counters
        lat = 1;
        bus.instr_ready = 1'b0;
        do_reset();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_ptr   = 32'hFFFF_FFFF;
        tick();
        bus.redirect_valid = 1'b0;
        chk("t6_drain_req", 32'(bus.imem_req_valid), 32'd0);
        tick();
        chk("t6_addr_max", bus.imem_req_addr, 32'hFFFF_FFFF);
        tick();
        chk("t6_wrap_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t6_wrap_addr", bus.imem_req_addr, 32'd0);
        bus.instr_ready = 1'b1;
        next_instr("t6_imax", 32'hFFFF_FFFF);
        next_instr("t6_i0", 32'd0);
`ifdef FETCH_PERF_EN
        chk("t6_perf_stall", perf_stall_cnt, 32'd1);
        chk("t6_perf_flush", perf_flush_cnt, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Instruction-fetch sequencer that sits between the instruction memory and core.
- Issues word-addressed fetch requests over a valid/ready port and buffers returned words in a small prefetch queue.
- Presents instructions to the core with a valid/ready handshake.
- Handles control-flow redirects by flushing the queue and discarding in-flight responses.

Parameters:
- DEPTH, 2, prefetch queue entries and maximum outstanding-plus-buffered fetches; power of two, at least 2.
- RESET_PTR, 32'd1, first instruction pointer fetched after reset.

Ports:
- clk  input  1  system clock, all state on rising edge.
- _reset  input  1  synchronous, active-high reset.
- redirect_valid  input  1  core requests fetch restart, for example on a taken jump.
- redirect_ptr  input  32  new instruction pointer, valid with redirect_valid.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word address being fetched.
- imem_resp_valid  input  1  response word valid; responses in order, latency at least 1 cycle, never back-pressured.
- imem_resp_data  input  32  fetched instruction word.
- instr_valid  output  1  queue head valid to core.
- instr_ready  input  1  core consumes head this cycle.
- instr_out  output  32  head instruction word.
- instr_ptr  output  32  pointer of head instruction.

Behaviour:
- Reset values, on the clock edge where _reset=1:
  - state=IDLE, queue empty, outstanding=0, drop_cnt=0.
  - fetch_ptr=RESET_PTR, head_ptr=RESET_PTR.
  - imem_req_valid=0, instr_valid=0, instr_out=0.
- Reset mid-operation abandons all state. Responses that arrive after reset for pre-reset requests are not excluded by the design; the bench holds the memory in reset as well.
- States:
  - IDLE: one cycle, then FETCH.
  - FETCH: normal issue.
  - DRAIN: discards responses for flushed requests.
- Issue rule, FETCH only: imem_req_valid=1 when outstanding + occupancy < DEPTH. imem_req_addr=fetch_ptr.
- A request fires when imem_req_valid & imem_req_ready; then fetch_ptr += 1 (32-bit wrap) and outstanding += 1.
- Response rule:
  - If drop_cnt>0, the response is discarded: drop_cnt -= 1, outstanding -= 1.
  - Otherwise, push {imem_resp_data} into the queue and outstanding -= 1.
  - The credit rule guarantees the push never overflows; an assertion checks it.
- Issue and response in the same cycle: outstanding is unchanged.
- Consume: instr_valid = queue not empty. On instr_valid & instr_ready, pop the head and head_ptr += 1.
- instr_out and instr_ptr come combinationally from the queue head and head_ptr.
- Fetch-to-instruction latency: at least 2 cycles, 1 to issue plus memory latency, with the head visible the cycle after the push.
- Redirect (redirect_valid=1), in any state except IDLE:
  - The queue is flushed and fetch_ptr=head_ptr=redirect_ptr.
  - drop_cnt = outstanding after this cycle's issue and response accounting.
  - A response arriving in the same cycle is dropped.
  - A request firing in the same cycle is counted in drop_cnt.
  - A pop in the same cycle is honoured by the core, but head_ptr takes redirect_ptr.
  - Next state is DRAIN if the new drop_cnt>0, else FETCH.
- Redirect during DRAIN: pointers reload and drop_cnt continues counting down, since no new requests were issued.
- DRAIN: imem_req_valid=0. When the last dropped response arrives (drop_cnt 1->0), the next state is FETCH.
- A redirect asserted during IDLE is ignored.
- Queue full plus an outstanding response is impossible by the credit rule.
- Queue empty with instr_ready=1 has no effect.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, add outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0 and saturating at 32'hFFFF_FFFF.
  - perf_stall_cnt increments each cycle instr_ready=1 & instr_valid=0 outside IDLE.
  - perf_flush_cnt increments on each accepted redirect.
- When not defined, neither port nor counter exists. Core behaviour is identical.

Decomposition:
- Shared types package:
  - fetch_state_t enum {IDLE, FETCH, DRAIN}.
  - Constant FETCH_RESET_PTR=32'd1, the default for RESET_PTR.
  - fetch_req_t struct {valid, addr[31:0]}.
- One sub-module, fetch_queue: a synchronous FIFO (DEPTH, 32-bit) with push, pop, flush, full, empty and count.
  - Flush has priority over push and pop.

Test Plan:
1. Reset, memory latency 1, imem_req_ready=1, instr_ready=1, memory returns addr*3 -> first request addr=1, instr_valid at cycle 3 with instr_ptr=1 and instr_out=3, then one instruction per cycle with ptr 2, 3, 4.
2. instr_ready=0 for 10 cycles -> exactly DEPTH=2 requests issued (addr 1, 2), queue full, imem_req_valid=0; release -> ptr 1, 2 delivered and fetch resumes at addr 3.
3. Latency 3, two requests outstanding, redirect_ptr=32'h40 -> both responses dropped, no instr_valid until the response for 32'h40, which shows instr_ptr=32'h40.
4. Redirect in the same cycle as a response and a request fire -> the response is dropped, drop_cnt=outstanding, and the state is DRAIN until those return.
5. Second redirect to 32'h80 during DRAIN -> no extra requests; after the drain, the first request is addr 32'h80.
6. fetch_ptr=32'hFFFF_FFFF via redirect -> next request addr 0 (wrap). With FETCH_PERF_EN, perf_flush_cnt=1 and stall count matches the starved cycles.
